// File: rtl/pmod_acl2_stream_assembler.sv
// rtl/pmod_acl2_stream_assembler.sv - byte stream to N-byte group assembler with show-ahead FIFO
// Optional error counters: define ACL_STREAM_ERR_COUNTERS_EN to implement them.
module pmod_acl2_stream_assembler #(
  parameter int parm_bytes_per_group = 8,
  parameter int parm_msb_first       = 1,
  parameter int parm_fifo_depth_bits = 2,
  parameter int parm_timeout_cycles  = 4096
) (
  input  logic                                i_clk_20mhz,
  input  logic                                i_rst_20mhz,
  input  logic [7:0]                          i_rd_data_stream,
  input  logic                                i_rd_data_byte_valid,
  input  logic                                i_rd_data_group_valid,
  output logic [8*parm_bytes_per_group-1:0]   o_data_group,
  output logic                                o_data_valid,
  input  logic                                i_data_ready,
  output logic [parm_fifo_depth_bits:0]       o_fifo_count,
  output logic                                o_busy,
  output logic [7:0]                          o_cnt_short,
  output logic [7:0]                          o_cnt_timeout,
  output logic [7:0]                          o_cnt_overflow
);

  localparam int LP_W     = 8 * parm_bytes_per_group;
  localparam int LP_DEPTH = 1 << parm_fifo_depth_bits;
  localparam int LP_CW    = parm_fifo_depth_bits + 1;
  localparam int LP_JW    = $clog2(parm_bytes_per_group + 1);
  localparam int LP_TW    = $clog2(parm_timeout_cycles) + 1;

  typedef enum logic [1:0] {
    ST_WAIT_GROUP = 2'd0,
    ST_CAPTURE    = 2'd1,
    ST_DONE_CYCLE = 2'd2,
    ST_DISCARD    = 2'd3
  } state_t;

  state_t                       r_state;
  state_t                       w_state_next;
  logic [LP_JW-1:0]             r_j;
  logic [LP_JW-1:0]             w_j_next;
  logic [LP_W-1:0]              r_asm;
  logic [LP_W-1:0]              w_byte_ext;
  logic [LP_TW-1:0]             r_timer;
  logic                         w_push;
  logic                         w_pop;
  logic                         w_full;
  logic                         w_accept;
  logic [LP_W-1:0]              r_mem [LP_DEPTH];
  logic [parm_fifo_depth_bits-1:0] r_wr_ptr;
  logic [parm_fifo_depth_bits-1:0] r_rd_ptr;
  logic [LP_CW-1:0]             r_count;

  // Byte count including a byte arriving this cycle, so a group completed on the falling edge counts as good
  always_comb begin
    w_j_next = r_j;
    if (r_state == ST_CAPTURE && i_rd_data_byte_valid) w_j_next = r_j + LP_JW'(1);
    w_byte_ext      = '0;
    w_byte_ext[7:0] = i_rd_data_stream;
  end

  // State register
  always_ff @(posedge i_clk_20mhz or posedge i_rst_20mhz) begin
    if (i_rst_20mhz) r_state <= ST_WAIT_GROUP;
    else             r_state <= w_state_next;
  end

  // Next-state logic; short beats completion beats timeout
  always_comb begin
    w_state_next = r_state;
    w_push       = 1'b0;
    case (r_state)
      ST_WAIT_GROUP: if (i_rd_data_group_valid) w_state_next = ST_CAPTURE;
      ST_CAPTURE: begin
        if (!i_rd_data_group_valid && w_j_next < LP_JW'(parm_bytes_per_group))
          w_state_next = ST_WAIT_GROUP;
        else if (w_j_next == LP_JW'(parm_bytes_per_group))
          w_state_next = ST_DONE_CYCLE;
        else if (r_timer == LP_TW'(parm_timeout_cycles))
          w_state_next = ST_DISCARD;
      end
      ST_DONE_CYCLE: if (!i_rd_data_group_valid) begin
        w_push       = 1'b1;
        w_state_next = ST_WAIT_GROUP;
      end
      ST_DISCARD: if (!i_rd_data_group_valid) w_state_next = ST_WAIT_GROUP;
      default: w_state_next = ST_WAIT_GROUP;
    endcase
  end

  // Assembly register, byte counter and inter-byte idle timer
  always_ff @(posedge i_clk_20mhz or posedge i_rst_20mhz) begin
    if (i_rst_20mhz) begin
      r_j     <= '0;
      r_asm   <= '0;
      r_timer <= '0;
    end else if (r_state == ST_WAIT_GROUP) begin
      r_j     <= '0;
      r_asm   <= '0;
      r_timer <= '0;
    end else if (r_state == ST_CAPTURE) begin
      r_j <= w_j_next;
      if (i_rd_data_byte_valid) begin
        r_timer <= '0;
        if (parm_msb_first != 0) begin
          r_asm <= (r_asm << 8) | w_byte_ext;
        end else begin
          for (int k = 0; k < parm_bytes_per_group; k++)
            if (r_j == LP_JW'(k)) r_asm[8*k +: 8] <= i_rd_data_stream;
        end
      end else begin
        r_timer <= r_timer + LP_TW'(1);
      end
    end else begin
      r_timer <= '0;
    end
  end

  assign w_pop    = (r_count != '0) && i_data_ready;
  assign w_full   = (r_count == LP_CW'(LP_DEPTH));
  assign w_accept = w_push && (!w_full || w_pop);

  // FIFO storage; contents are only meaningful where the pointers say so
  always_ff @(posedge i_clk_20mhz) begin
    if (w_accept) r_mem[r_wr_ptr] <= r_asm;
  end

  // FIFO pointers and occupancy
  always_ff @(posedge i_clk_20mhz or posedge i_rst_20mhz) begin
    if (i_rst_20mhz) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_accept) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)    r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_accept, w_pop})
        2'b10:   r_count <= r_count + LP_CW'(1);
        2'b01:   r_count <= r_count - LP_CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_data_valid = (r_count != '0);
  assign o_data_group = o_data_valid ? r_mem[r_rd_ptr] : '0;
  assign o_fifo_count = r_count;
  assign o_busy       = (r_state != ST_WAIT_GROUP);

`ifdef ACL_STREAM_ERR_COUNTERS_EN
  logic       w_short;
  logic       w_timeout;
  logic       w_overflow;
  logic [7:0] r_cnt_short;
  logic [7:0] r_cnt_timeout;
  logic [7:0] r_cnt_overflow;

  assign w_short    = (r_state == ST_CAPTURE) && (w_state_next == ST_WAIT_GROUP);
  assign w_timeout  = (r_state == ST_CAPTURE) && (w_state_next == ST_DISCARD);
  assign w_overflow = w_push && w_full && !w_pop;

  // Saturating error counters, cleared only by reset
  always_ff @(posedge i_clk_20mhz or posedge i_rst_20mhz) begin
    if (i_rst_20mhz) begin
      r_cnt_short    <= 8'h00;
      r_cnt_timeout  <= 8'h00;
      r_cnt_overflow <= 8'h00;
    end else begin
      if (w_short && r_cnt_short != 8'hFF)       r_cnt_short    <= r_cnt_short + 8'd1;
      if (w_timeout && r_cnt_timeout != 8'hFF)   r_cnt_timeout  <= r_cnt_timeout + 8'd1;
      if (w_overflow && r_cnt_overflow != 8'hFF) r_cnt_overflow <= r_cnt_overflow + 8'd1;
    end
  end

  assign o_cnt_short    = r_cnt_short;
  assign o_cnt_timeout  = r_cnt_timeout;
  assign o_cnt_overflow = r_cnt_overflow;
`else
  assign o_cnt_short    = 8'h00;
  assign o_cnt_timeout  = 8'h00;
  assign o_cnt_overflow = 8'h00;
`endif

endmodule

// File: tb/tb_pmod_acl2_stream_assembler.sv
// tb/tb_pmod_acl2_stream_assembler.sv - randomized self-checking bench against a queue-based group model
module tb_pmod_acl2_stream_assembler;
  localparam int N     = 8;
  localparam int DB    = 2;
  localparam int DEPTH = 4;
  localparam int T     = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  data;
  logic        bv, gv, ready;

  logic [63:0] a_group, b_group;
  logic        a_valid, b_valid, a_busy, b_busy;
  logic [2:0]  a_count, b_count;
  logic [7:0]  a_cs, a_ct, a_co, b_cs, b_ct, b_co;

  pmod_acl2_stream_assembler #(.parm_bytes_per_group(N), .parm_msb_first(1),
    .parm_fifo_depth_bits(DB), .parm_timeout_cycles(T)) u_dut_msb (
    .i_clk_20mhz(clk), .i_rst_20mhz(rst), .i_rd_data_stream(data),
    .i_rd_data_byte_valid(bv), .i_rd_data_group_valid(gv),
    .o_data_group(a_group), .o_data_valid(a_valid), .i_data_ready(ready),
    .o_fifo_count(a_count), .o_busy(a_busy),
    .o_cnt_short(a_cs), .o_cnt_timeout(a_ct), .o_cnt_overflow(a_co));

  pmod_acl2_stream_assembler #(.parm_bytes_per_group(N), .parm_msb_first(0),
    .parm_fifo_depth_bits(DB), .parm_timeout_cycles(T)) u_dut_lsb (
    .i_clk_20mhz(clk), .i_rst_20mhz(rst), .i_rd_data_stream(data),
    .i_rd_data_byte_valid(bv), .i_rd_data_group_valid(gv),
    .o_data_group(b_group), .o_data_valid(b_valid), .i_data_ready(ready),
    .o_fifo_count(b_count), .o_busy(b_busy),
    .o_cnt_short(b_cs), .o_cnt_timeout(b_ct), .o_cnt_overflow(b_co));

  always #25 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [63:0] q_msb[$];
  logic [63:0] q_lsb[$];
  int          m_short, m_timeout, m_ovf;
  int          ready_mode;
  logic [7:0]  g_bytes [N];
  logic [63:0] cur_msb, cur_lsb;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int exp_cnt(input int v);
    int r;
    r = (v > 255) ? 255 : v;
`ifndef ACL_STREAM_ERR_COUNTERS_EN
    r = 0;
`endif
    return r;
  endfunction

  // First byte is the most significant in one packing, the least significant in the other
  task automatic pack_bytes();
    cur_msb = '0;
    cur_lsb = '0;
    for (int i = 0; i < N; i++) begin
      cur_msb = cur_msb | (64'(g_bytes[i]) << (8 * (N - 1 - i)));
      cur_lsb = cur_lsb | (64'(g_bytes[i]) << (8 * i));
    end
  endtask

  task automatic compare_outputs();
    logic        ev;
    logic [63:0] em, el;
    ev = (q_msb.size() > 0);
    em = ev ? q_msb[0] : 64'h0;
    el = ev ? q_lsb[0] : 64'h0;
    check_eq("valid_msb", 64'(a_valid), 64'(ev));
    check_eq("valid_lsb", 64'(b_valid), 64'(ev));
    check_eq("count_msb", 64'(a_count), 64'(q_msb.size()));
    check_eq("count_lsb", 64'(b_count), 64'(q_lsb.size()));
    check_eq("head_msb", a_group, em);
    check_eq("head_lsb", b_group, el);
  endtask

  task automatic check_counters();
    check_eq("cnt_short_msb", 64'(a_cs), 64'(exp_cnt(m_short)));
    check_eq("cnt_short_lsb", 64'(b_cs), 64'(exp_cnt(m_short)));
    check_eq("cnt_timeout_msb", 64'(a_ct), 64'(exp_cnt(m_timeout)));
    check_eq("cnt_timeout_lsb", 64'(b_ct), 64'(exp_cnt(m_timeout)));
    check_eq("cnt_overflow_msb", 64'(a_co), 64'(exp_cnt(m_ovf)));
    check_eq("cnt_overflow_lsb", 64'(b_co), 64'(exp_cnt(m_ovf)));
  endtask

  // One clock: drive inputs, advance the group/FIFO model, then compare
  task automatic step(input logic g, input logic v, input logic [7:0] d, input bit push);
    bit pop;
    gv   = g;
    bv   = v;
    data = d;
    ready = (ready_mode == 0) ? 1'b0 : (ready_mode == 1) ? 1'b1 : ($urandom_range(0, 2) == 0);
    pop = ready && (q_msb.size() > 0);
    @(posedge clk);
    #1;
    if (pop) begin
      void'(q_msb.pop_front());
      void'(q_lsb.pop_front());
    end
    if (push) begin
      if (q_msb.size() < DEPTH) begin
        q_msb.push_back(cur_msb);
        q_lsb.push_back(cur_lsb);
      end else begin
        m_ovf++;
      end
    end
    compare_outputs();
  endtask

  task automatic good_group(input bit fall, input int max_gap, input bit directed);
    for (int i = 0; i < N; i++) g_bytes[i] = directed ? 8'(i + 1) : 8'($urandom);
    pack_bytes();
    step(1, 0, 8'($urandom), 0);
    for (int i = 0; i < N; i++) begin
      repeat ($urandom_range(0, max_gap)) step(1, 0, 8'($urandom), 0);
      if (i == N - 1 && fall) step(0, 1, g_bytes[i], 0);
      else                    step(1, 1, g_bytes[i], 0);
    end
    if (!fall) repeat ($urandom_range(0, 3)) step(1, 1'($urandom_range(0, 1)), 8'($urandom), 0);
    step(0, 0, 8'h00, 1);
    step(0, 1'($urandom_range(0, 1)), 8'($urandom), 0);
    check_counters();
  endtask

  task automatic short_group(input int k);
    step(1, 0, 8'h00, 0);
    for (int i = 0; i < k; i++) begin
      repeat ($urandom_range(0, 3)) step(1, 0, 8'($urandom), 0);
      step(1, 1, 8'($urandom), 0);
    end
    repeat ($urandom_range(0, 3)) step(1, 0, 8'($urandom), 0);
    step(0, 0, 8'h00, 0);
    m_short++;
    step(0, 0, 8'h00, 0);
  endtask

  task automatic timeout_group(input int k);
    step(1, 0, 8'h00, 0);
    for (int i = 0; i < k; i++) begin
      repeat ($urandom_range(0, 3)) step(1, 0, 8'($urandom), 0);
      step(1, 1, 8'($urandom), 0);
    end
    repeat (T + 2) step(1, 0, 8'($urandom), 0);
    m_timeout++;
    check_eq("busy_discard_msb", 64'(a_busy), 64'd1);
    check_eq("busy_discard_lsb", 64'(b_busy), 64'd1);
    repeat (3) step(1, 1, 8'($urandom), 0);
    check_eq("busy_still_msb", 64'(a_busy), 64'd1);
    step(0, 0, 8'h00, 0);
    check_eq("busy_after_msb", 64'(a_busy), 64'd0);
    check_eq("busy_after_lsb", 64'(b_busy), 64'd0);
    check_counters();
  endtask

  initial begin
    m_short = 0; m_timeout = 0; m_ovf = 0;
    ready_mode = 0;
    rst = 1'b1; gv = 0; bv = 0; data = 0; ready = 0;
    repeat (2) @(posedge clk);
    #1;
    compare_outputs();
    check_eq("busy_reset", 64'(a_busy), 64'd0);
    check_counters();
    rst = 1'b0;

    // Directed 01..08 group, both packings
    good_group(0, 2, 1);
    check_eq("directed_msb", a_group, 64'h0102030405060708);
    check_eq("directed_lsb", b_group, 64'h0807060504030201);
    ready_mode = 1;
    repeat (3) step(0, 0, 8'h00, 0);

    // Completion on the falling edge, short group, then good group
    good_group(1, 1, 0);
    short_group(5);
    check_counters();
    good_group(0, T - 1, 0);
    timeout_group(3);
    repeat (3) step(0, 0, 8'h00, 0);

    // Overflow: five groups into a four-deep FIFO, then drain in order
    ready_mode = 0;
    for (int i = 0; i < 5; i++) good_group(i[0], 2, 0);
    check_eq("ovf_count", 64'(a_count), 64'd4);
    ready_mode = 1;
    repeat (8) step(0, 0, 8'h00, 0);
    check_counters();

    // Reset mid-group with two entries queued
    ready_mode = 0;
    good_group(0, 1, 0);
    good_group(1, 1, 0);
    step(1, 0, 8'h00, 0);
    for (int i = 0; i < 4; i++) step(1, 1, 8'($urandom), 0);
    #5 rst = 1'b1;
    #1;
    q_msb.delete(); q_lsb.delete();
    m_short = 0; m_timeout = 0; m_ovf = 0;
    compare_outputs();
    check_eq("busy_midreset", 64'(a_busy), 64'd0);
    check_counters();
    gv = 0; bv = 0;
    @(posedge clk);
    #5 rst = 1'b0;
    good_group(0, 2, 0);

    // Randomized traffic with random consumer backpressure
    ready_mode = 2;
    for (int it = 0; it < 60; it++) begin
      case ($urandom_range(0, 5))
        0, 1, 2: good_group(1'($urandom_range(0, 1)), ($urandom_range(0, 4) == 0) ? T - 1 : 3, 0);
        3, 4:    short_group($urandom_range(0, N - 1));
        default: timeout_group($urandom_range(0, N - 1));
      endcase
    end
    ready_mode = 1;
    repeat (6) step(0, 0, 8'h00, 0);

    // Short counter saturation
    for (int i = 0; i < 260; i++) begin
      step(1, 0, 8'h00, 0);
      step(0, 0, 8'h00, 0);
      m_short++;
      step(0, 0, 8'h00, 0);
    end
    check_counters();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pmod_acl2_stream_assembler.md
# pmod_acl2_stream_assembler

Parametrised successor to the fixed 8-byte measurement capture in the ACL2 driver. It assembles a byte stream, framed by a group-valid level and qualified by byte-valid pulses, into groups of a configurable byte count and order. Complete groups go into a small show-ahead FIFO with a valid/ready output handshake. Short, timed-out and overflowed groups are discarded. The block sits between `pmod_acl2_stand_spi_solo` (stream outputs) and the display/UART consumers.

## Interface
Parameters:
- `parm_bytes_per_group`, 8: bytes per complete group N (range 1..16).
- `parm_msb_first`, 1: 1 = first received byte lands in the most-significant byte; 0 = first byte lands in the least-significant byte.
- `parm_fifo_depth_bits`, 2: FIFO depth is 2**bits entries.
- `parm_timeout_cycles`, 4096: maximum idle cycles between bytes inside a group before the group is aborted.

Ports:
- `i_clk_20mhz`  in  1  sole clock.
- `i_rst_20mhz`  in  1  reset, asynchronous, active-high.
- `i_rd_data_stream`  in  8  stream byte.
- `i_rd_data_byte_valid`  in  1  one-cycle strobe qualifying `i_rd_data_stream`.
- `i_rd_data_group_valid`  in  1  level, high for the duration of a group.
- `o_data_group`  out  8*N  FIFO head; all zeros when the FIFO is empty.
- `o_data_valid`  out  1  FIFO not empty.
- `i_data_ready`  in  1  consumer accepts the head; a pop occurs when valid && ready.
- `o_fifo_count`  out  `parm_fifo_depth_bits`+1  FIFO occupancy.
- `o_busy`  out  1  FSM not in ST_WAIT_GROUP.
- `o_cnt_short`, `o_cnt_timeout`, `o_cnt_overflow`  out  8 each  saturating error counters.

## Operation
- FSM states:
  - ST_WAIT_GROUP: clears the byte counter j and the assembly register; moves to ST_CAPTURE when group_valid=1.
  - ST_CAPTURE: on each byte_valid, store the byte and increment j. Transitions, in priority order:
    1. group_valid=0 with j<N: short group, discard, increment short counter, go to ST_WAIT_GROUP.
    2. j==N: go to ST_DONE_CYCLE.
    3. Idle timer reaches `parm_timeout_cycles`: increment timeout counter, go to ST_DISCARD.
  - ST_DONE_CYCLE: ignores further byte_valid (excess bytes dropped, no error). When group_valid=0, push the group and go to ST_WAIT_GROUP.
  - ST_DISCARD: waits for group_valid=0, then goes to ST_WAIT_GROUP.
  - Undefined or illegal state encodings go to ST_WAIT_GROUP.
- Byte placement:
  - `parm_msb_first`=1: register shifts left, new byte in [7:0]. After N bytes the first byte sits in [8N-1:8N-8].
  - `parm_msb_first`=0: byte j is written to [8j+7:8j].
- Idle timer: clears on entry to ST_CAPTURE and on every byte_valid; counts otherwise. Width is clog2(`parm_timeout_cycles`)+1.
- byte_valid outside ST_CAPTURE is ignored.
- FIFO:
  - A push while full (with no simultaneous pop) is dropped and increments the overflow counter. Stored contents are unchanged.
  - A simultaneous push and pop when full is accepted; count stays unchanged.
  - A simultaneous push and pop when empty: the pop has no effect and the push is stored.
  - Pointers wrap modulo depth.
- Counters saturate at 255 and clear only on reset.

## Timing
- Reset (asynchronous) values: state ST_WAIT_GROUP; `o_data_valid`=0, `o_data_group`=0, `o_fifo_count`=0, `o_busy`=0, all counters 0. Reset mid-group discards the group and all FIFO contents.
- Bytes are registered on the edge where byte_valid=1; back-to-back byte_valid on consecutive cycles is supported.
- The push occurs on the edge where ST_DONE_CYCLE samples group_valid=0. `o_data_valid` and the updated `o_data_group` appear after that edge, i.e. one cycle of latency from group_valid falling.
- A pop takes effect on the edge where valid && ready; the next head (or zeros) is presented in the following cycle.
- The short-group decision is made on the first cycle ST_CAPTURE sees group_valid=0. A byte_valid in that same cycle is still counted first, so completing the group exactly on the group_valid falling edge yields a good group (proceed via ST_DONE_CYCLE).
- The timeout fires on the cycle the idle timer equals `parm_timeout_cycles`.

## Configuration
- `ACL_STREAM_ERR_COUNTERS_EN`:
  - Defined: the three saturating counters are implemented as described.
  - Undefined: counter logic is removed and `o_cnt_short`, `o_cnt_timeout` and `o_cnt_overflow` are tied to 8'h00. All discard behaviour is identical.

## Test plan
- N=8, msb_first=1: group of bytes 01..08, then group_valid low -> `o_data_group`=64'h0102030405060708, valid high one cycle after the falling edge.
- msb_first=0, same stimulus -> `o_data_group`=64'h0807060504030201.
- Group of 5 bytes then group_valid low -> no push, `o_cnt_short`=1; a following good group is accepted intact.
- `parm_timeout_cycles`=16: 3 bytes, then 16 idle cycles with group_valid high -> `o_cnt_timeout`=1, `o_busy` stays high until group_valid low, no push.
- depth 4, ready=0: 5 good groups -> `o_fifo_count`=4, `o_cnt_overflow`=1, head = group 1. With ready=1 the heads drain in order 1..4, then valid=0 and data=0.
- Assert reset mid-group after 4 bytes with 2 entries queued -> all outputs 0 immediately; next full group is captured correctly.
